// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the snake game controller and the surrounding game logic.
// The master drives the buttons and the length-stage feedback; the slave drives the state and strobes.
interface snake_game_ctrl_if;
    logic       Start;
    logic       Pause_Btn;
    logic       Ack;
    logic       Collision;
    logic [7:0] Length;
    logic       q_I;
    logic       q_Run;
    logic       q_Pause;
    logic       q_Win;
    logic       q_Lose;
    logic       Speed_Clk;
    logic       Game_Clear;
    logic [7:0] Best_Length;

    modport master (
        output Start, Pause_Btn, Ack, Collision, Length,
        input  q_I, q_Run, q_Pause, q_Win, q_Lose, Speed_Clk, Game_Clear, Best_Length
    );

    modport slave (
        input  Start, Pause_Btn, Ack, Collision, Length,
        output q_I, q_Run, q_Pause, q_Win, q_Lose, Speed_Clk, Game_Clear, Best_Length
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// Game-level state machine for the snake game. It produces the move strobe, which speeds up as the
// snake grows, and the clear pulse between games. It also tracks the best length reached.
module snake_game_ctrl #(
    parameter int TICK_DIV     = 25000000,
    parameter int SPEEDUP_STEP = 1000000,
    parameter int MIN_DIV      = 5000000,
    parameter int INIT_LEN     = 3,
    parameter int WIN_LENGTH   = 225,
    parameter int CNT_W        = 27
) (
    input  logic               Clk,
    input  logic               Reset,
    snake_game_ctrl_if.slave   bus
);

    localparam int PW = CNT_W + 8;
    localparam logic [PW-1:0]    TICK_W   = PW'(TICK_DIV);
    localparam logic [PW-1:0]    MIN_W    = PW'(MIN_DIV);
    localparam logic [PW-1:0]    STEP_W   = PW'(SPEEDUP_STEP);
    localparam logic [7:0]       INIT_L   = 8'(INIT_LEN);
    localparam logic [7:0]       WIN_L    = 8'(WIN_LENGTH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    // One-hot encoding: each bit drives one q_* output directly from a flop.
    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_RUN   = 5'b00010,
        S_PAUSE = 5'b00100,
        S_WIN   = 5'b01000,
        S_LOSE  = 5'b10000
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_period_q, cur_period_d;
    logic             speed_clk_q, speed_clk_d;
    logic             game_clear_q, game_clear_d;
    logic [7:0]       best_length_q, best_length_d;

    logic [7:0]       grown;
    logic [PW-1:0]    shrink;
    logic [PW-1:0]    next_period;

    // The wide datapath keeps the subtraction from wrapping before the clamp is applied.
    always_comb begin
        grown  = (bus.Length > INIT_L) ? bus.Length - INIT_L : 8'd0;
        shrink = PW'(grown) * STEP_W;
        if (shrink >= TICK_W - MIN_W) next_period = MIN_W;
        else                          next_period = TICK_W - shrink;
    end

    // NOTE: every variable gets its default first, so that no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cur_period_d  = cur_period_q;
        speed_clk_d   = 1'b0;
        game_clear_d  = 1'b0;
        best_length_d = best_length_q;
        case (state_q)
            S_INIT: begin
                if (bus.Start && !bus.Collision) begin
                    state_d      = S_RUN;
                    cnt_d        = '0;
                    cur_period_d = CNT_W'(TICK_DIV);
                end
            end
            S_RUN: begin
                if (bus.Collision || bus.Length >= WIN_L) begin
                    state_d = bus.Collision ? S_LOSE : S_WIN;
                    if (bus.Length > best_length_q) best_length_d = bus.Length;
                end else if (bus.Ack) begin
                    state_d      = S_INIT;
                    game_clear_d = 1'b1;
                end else if (bus.Pause_Btn) begin
                    state_d = S_PAUSE;
                end else if (cnt_q == cur_period_q - ONE) begin
                    cnt_d        = '0;
                    speed_clk_d  = 1'b1;
                    cur_period_d = CNT_W'(next_period);
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_PAUSE: begin
                if (bus.Ack) begin
                    state_d      = S_INIT;
                    game_clear_d = 1'b1;
                end else if (bus.Pause_Btn) begin
                    state_d = S_RUN;
                end
            end
            S_WIN, S_LOSE: begin
                if (bus.Ack) begin
                    state_d      = S_INIT;
                    game_clear_d = 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop samples the pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= S_INIT;
            cnt_q         <= '0;
            cur_period_q  <= CNT_W'(TICK_DIV);
            speed_clk_q   <= 1'b0;
            game_clear_q  <= 1'b0;
            best_length_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cur_period_q  <= cur_period_d;
            speed_clk_q   <= speed_clk_d;
            game_clear_q  <= game_clear_d;
            best_length_q <= best_length_d;
        end
    end

    assign bus.q_I         = state_q[0];
    assign bus.q_Run       = state_q[1];
    assign bus.q_Pause     = state_q[2];
    assign bus.q_Win       = state_q[3];
    assign bus.q_Lose      = state_q[4];
    assign bus.Speed_Clk   = speed_clk_q;
    assign bus.Game_Clear  = game_clear_q;
    assign bus.Best_Length = best_length_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: vector table, directed timing sequences and random traffic
// compared against a countdown-based reference model.
module tb_snake_game_ctrl;

    localparam int TICK = 10, STEP = 2, MIN = 4, ILEN = 3, WIN_A = 6, WIN_B = 20, CW = 8;
    localparam logic [4:0] QI = 5'b00001, QR = 5'b00010, QP = 5'b00100, QW = 5'b01000, QL = 5'b10000;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    snake_game_ctrl_if bus_a ();
    snake_game_ctrl_if bus_b ();

    snake_game_ctrl #(.TICK_DIV(TICK), .SPEEDUP_STEP(STEP), .MIN_DIV(MIN), .INIT_LEN(ILEN),
                      .WIN_LENGTH(WIN_A), .CNT_W(CW))
        dut_a (.Clk(Clk), .Reset(Reset), .bus(bus_a.slave));

    snake_game_ctrl #(.TICK_DIV(TICK), .SPEEDUP_STEP(STEP), .MIN_DIV(MIN), .INIT_LEN(ILEN),
                      .WIN_LENGTH(WIN_B), .CNT_W(CW))
        dut_b (.Clk(Clk), .Reset(Reset), .bus(bus_b.slave));

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [4:0] q_a();
        return {bus_a.q_Lose, bus_a.q_Win, bus_a.q_Pause, bus_a.q_Run, bus_a.q_I};
    endfunction

    function automatic logic [4:0] q_b();
        return {bus_b.q_Lose, bus_b.q_Win, bus_b.q_Pause, bus_b.q_Run, bus_b.q_I};
    endfunction

    task automatic drive_a(input logic s, p, a, c, input logic [7:0] len);
        bus_a.Start = s; bus_a.Pause_Btn = p; bus_a.Ack = a; bus_a.Collision = c; bus_a.Length = len;
    endtask

    task automatic drive_b(input logic s, p, a, c, input logic [7:0] len);
        bus_b.Start = s; bus_b.Pause_Btn = p; bus_b.Ack = a; bus_b.Collision = c; bus_b.Length = len;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        logic       start, pause, ack, coll;
        logic [7:0] len;
        logic [4:0] q;
        logic       spd, clr;
        logic [7:0] best;
    } vec_t;

    vec_t vecs[19];

    // Reference model: game mode plus the number of RUN cycles left until the next move.
    typedef enum int {M_INIT, M_RUN, M_PAUSE, M_WIN, M_LOSE} mode_e;
    mode_e m_mode;
    int    m_left, m_best;
    logic  m_spd, m_clr;

    function automatic int period_for(input int len);
        int grown, p;
        grown = (len > ILEN) ? len - ILEN : 0;
        p = TICK - grown * STEP;
        return (p < MIN) ? MIN : p;
    endfunction

    task automatic model_edge(input logic s, p, a, c, input int len);
        m_spd = 1'b0;
        m_clr = 1'b0;
        case (m_mode)
            M_INIT: if (s && !c) begin m_mode = M_RUN; m_left = TICK; end
            M_RUN: begin
                if (c || len >= WIN_B) begin
                    m_mode = c ? M_LOSE : M_WIN;
                    if (len > m_best) m_best = len;
                end else if (a) begin
                    m_mode = M_INIT; m_clr = 1'b1;
                end else if (p) begin
                    m_mode = M_PAUSE;
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_spd = 1'b1; m_left = period_for(len); end
                end
            end
            M_PAUSE: begin
                if (a) begin m_mode = M_INIT; m_clr = 1'b1; end
                else if (p) m_mode = M_RUN;
            end
            default: if (a) begin m_mode = M_INIT; m_clr = 1'b1; end
        endcase
    endtask

    initial begin
        int len;
        logic s, p, a, c;
        logic [4:0] exp_q;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd3, QR, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd6, QL, 1'b0, 1'b0, 8'd6};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd6, QL, 1'b0, 1'b0, 8'd6};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd6, QI, 1'b0, 1'b1, 8'd6};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd6, QI, 1'b0, 1'b0, 8'd6};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd3, QI, 1'b0, 1'b0, 8'd6};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd3, QR, 1'b0, 1'b0, 8'd6};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd6, QW, 1'b0, 1'b0, 8'd6};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd6, QW, 1'b0, 1'b0, 8'd6};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd6, QI, 1'b0, 1'b1, 8'd6};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd3, QR, 1'b0, 1'b0, 8'd6};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd4, QL, 1'b0, 1'b0, 8'd6};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd4, QI, 1'b0, 1'b1, 8'd6};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd3, QR, 1'b0, 1'b0, 8'd6};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd3, QP, 1'b0, 1'b0, 8'd6};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd7, QP, 1'b0, 1'b0, 8'd6};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd3, QR, 1'b0, 1'b0, 8'd6};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd3, QI, 1'b0, 1'b1, 8'd6};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd3, QI, 1'b0, 1'b0, 8'd6};

        drive_a(0, 0, 0, 0, 8'd3);
        drive_b(0, 0, 0, 0, 8'd3);
        Reset = 1'b1;
        #12;
        check("reset_q", q_a(), QI);
        check("reset_spd", bus_a.Speed_Clk, 0);
        check("reset_clr", bus_a.Game_Clear, 0);
        check("reset_best", bus_a.Best_Length, 0);
        #11 Reset = 1'b0;
        step();
        check("post_reset_clr", bus_a.Game_Clear, 0);

        // State/priority table
        foreach (vecs[i]) begin
            drive_a(vecs[i].start, vecs[i].pause, vecs[i].ack, vecs[i].coll, vecs[i].len);
            step();
            check($sformatf("vec%0d_q", i), q_a(), vecs[i].q);
            check($sformatf("vec%0d_spd", i), bus_a.Speed_Clk, vecs[i].spd);
            check($sformatf("vec%0d_clr", i), bus_a.Game_Clear, vecs[i].clr);
            check($sformatf("vec%0d_best", i), bus_a.Best_Length, vecs[i].best);
        end

        // Base rate: strobes at 10, 20, 30 cycles after entering RUN
        drive_a(1, 0, 0, 0, 8'd3);
        step();
        drive_a(0, 0, 0, 0, 8'd3);
        check("t1_run", q_a(), QR);
        check("t1_spd0", bus_a.Speed_Clk, 0);
        for (int cy = 1; cy <= 35; cy++) begin
            step();
            check($sformatf("t1_spd_c%0d", cy), bus_a.Speed_Clk, (cy % 10) == 0);
        end
        drive_a(0, 0, 1, 0, 8'd3);
        step();
        drive_a(0, 0, 0, 0, 8'd3);
        check("t1_ack_q", q_a(), QI);
        check("t1_ack_spd", bus_a.Speed_Clk, 0);

        // Length 5: first interval 10, then 6
        drive_a(1, 0, 0, 0, 8'd5);
        step();
        drive_a(0, 0, 0, 0, 8'd5);
        for (int cy = 1; cy <= 30; cy++) begin
            step();
            check($sformatf("t2_spd_c%0d", cy), bus_a.Speed_Clk,
                  cy == 10 || cy == 16 || cy == 22 || cy == 28);
        end
        drive_a(0, 0, 1, 0, 8'd3);
        step();
        drive_a(0, 0, 0, 0, 8'd3);

        // Length 8 clamps the period at MIN_DIV
        drive_b(1, 0, 0, 0, 8'd8);
        step();
        drive_b(0, 0, 0, 0, 8'd8);
        for (int cy = 1; cy <= 20; cy++) begin
            step();
            check($sformatf("t2b_spd_c%0d", cy), bus_b.Speed_Clk, cy == 10 || cy == 14 || cy == 18);
        end
        drive_b(0, 0, 1, 0, 8'd3);
        step();
        drive_b(0, 0, 0, 0, 8'd3);
        check("t2b_clr", bus_b.Game_Clear, 1);

        // Pause preserves the remaining interval
        drive_a(1, 0, 0, 0, 8'd3);
        step();
        drive_a(0, 0, 0, 0, 8'd3);
        for (int cy = 1; cy <= 13; cy++) step();
        check("t3_tick_seen", bus_a.Speed_Clk, 0);
        drive_a(0, 1, 0, 0, 8'd3);
        step();
        drive_a(0, 0, 0, 0, 8'd3);
        check("t3_paused", q_a(), QP);
        begin
            int pulses = 0;
            int paused = 0;
            for (int cy = 0; cy < 50; cy++) begin
                step();
                pulses += int'(bus_a.Speed_Clk);
                paused += int'(bus_a.q_Pause);
            end
            check("t3_no_spd_in_pause", pulses, 0);
            check("t3_pause_held", paused, 50);
        end
        drive_a(0, 1, 0, 0, 8'd3);
        step();
        drive_a(0, 0, 0, 0, 8'd3);
        check("t3_resumed", q_a(), QR);
        for (int cy = 1; cy <= 7; cy++) begin
            step();
            check($sformatf("t3_spd_r%0d", cy), bus_a.Speed_Clk, cy == 7);
        end

        // Asynchronous reset in the middle of an interval
        for (int cy = 0; cy < 4; cy++) step();
        #3 Reset = 1'b1;
        #1;
        check("t6_q", q_a(), QI);
        check("t6_spd", bus_a.Speed_Clk, 0);
        check("t6_best", bus_a.Best_Length, 0);
        check("t6_clr", bus_a.Game_Clear, 0);
        #2 Reset = 1'b0;
        step();
        check("t6_clr_after", bus_a.Game_Clear, 0);
        drive_a(1, 0, 0, 1, 8'd3);
        step();
        drive_a(0, 0, 0, 0, 8'd3);
        check("t6_start_coll", q_a(), QI);

        // Random traffic on the second instance, which was reset together with the first
        m_mode = M_INIT;
        m_left = TICK;
        m_best = 0;
        len = 3;
        for (int cy = 0; cy < 4000; cy++) begin
            s = ($urandom_range(7) == 0);
            p = ($urandom_range(59) == 0);
            a = ($urandom_range(149) == 0);
            c = ($urandom_range(199) == 0);
            if ($urandom_range(3) == 0) begin
                if ($urandom_range(1) == 0 && len < 25) len++;
                else if (len > 0) len--;
            end
            if ($urandom_range(299) == 0) len = $urandom_range(21);
            drive_b(s, p, a, c, 8'(len));
            @(posedge Clk);
            model_edge(s, p, a, c, len);
            #1;
            exp_q = 5'(1 << int'(m_mode));
            check($sformatf("rnd%0d", cy), {19'd0, q_b(), bus_b.Speed_Clk, bus_b.Game_Clear, bus_b.Best_Length},
                  {19'd0, exp_q, m_spd, m_clr, 8'(m_best)});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
